// File: rtl/clock_ctrl_pkg.sv
// Shared encodings for the time-of-day control FSM: set-mode states,
// digit positions in the blink mask, and the per-field blink masks.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_e;

  localparam int DIG_SEC_LSB  = 0;
  localparam int DIG_SEC_MSB  = 1;
  localparam int DIG_MIN_LSB  = 2;
  localparam int DIG_MIN_MSB  = 3;
  localparam int DIG_HOUR_LSB = 4;
  localparam int DIG_HOUR_MSB = 5;

  localparam logic [5:0] MASK_HOUR = 6'((1 << DIG_HOUR_MSB) | (1 << DIG_HOUR_LSB));
  localparam logic [5:0] MASK_MIN  = 6'((1 << DIG_MIN_MSB)  | (1 << DIG_MIN_LSB));
  localparam logic [5:0] MASK_SEC  = 6'((1 << DIG_SEC_MSB)  | (1 << DIG_SEC_LSB));

  // Width of a counter that runs 0..bound-1; never narrower than one bit.
  function automatic int cnt_width(input int bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

  // Digits of the field being edited blank only during the "off" blink phase.
  function automatic logic [5:0] state_mask(input state_e s, input logic phase);
    logic [5:0] m;
    m = '0;
    if (phase) begin
      case (s)
        SET_HOUR: m = MASK_HOUR;
        SET_MIN:  m = MASK_MIN;
        SET_SEC:  m = MASK_SEC;
        default:  m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Rising-edge detector with press-and-hold auto-repeat. pulse is
// combinational; the parent registers it into its strobe outputs.
module btn_repeat
  import clock_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic clr,
  output logic pulse
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic             r_btn_q;
  logic             r_active;
  logic             r_repeating;
  logic [CNT_W-1:0] r_cnt;
  logic             w_rise;
  logic             w_hit;

  assign w_rise = btn & ~r_btn_q;
  assign w_hit  = r_active & btn & (r_cnt == (r_repeating ? REP_LAST : HOLD_LAST));
  assign pulse  = w_rise | w_hit;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_btn_q     <= 1'b0;
      r_active    <= 1'b0;
      r_repeating <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_btn_q <= btn;
      // A mode change cancels the hold; a fresh press is needed to repeat again.
      if (clr || !btn) begin
        r_active    <= 1'b0;
        r_repeating <= 1'b0;
        r_cnt       <= '0;
      end else if (w_rise) begin
        r_active    <= 1'b1;
        r_repeating <= 1'b0;
        r_cnt       <= '0;
      end else if (w_hit) begin
        r_repeating <= 1'b1;
        r_cnt       <= '0;
      end else if (r_active) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-of-day control FSM: run-mode second tick, button-driven set mode with
// auto-repeat increments, idle timeout back to RUN, and display blink mask.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int CLK_HZ         = 100000000,
  parameter int TICK_HZ        = 1,
  parameter int BLINK_DIV      = 25000000,
  parameter int HOLD_CYCLES    = 50000000,
  parameter int REPEAT_CYCLES  = 10000000,
  parameter int TIMEOUT_CYCLES = 1000000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       tick_en,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       inc_hour,
  output logic [5:0] blink_mask,
  output logic [1:0] set_mode
);

  localparam int DIV    = CLK_HZ / TICK_HZ;
  localparam int PRE_W  = cnt_width(DIV);
  localparam int IDLE_W = cnt_width(TIMEOUT_CYCLES);
  localparam int BLK_W  = cnt_width(BLINK_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(DIV - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_DIV - 1);

  state_e              r_state;
  logic                r_mode_q;
  logic [PRE_W-1:0]    r_pre;
  logic [IDLE_W-1:0]   r_idle;
  logic [BLK_W-1:0]    r_blk;
  logic                r_phase;

  state_e              w_next_state;
  logic                w_rise_mode;
  logic                w_inc_pulse;
  logic                w_timeout;
  logic                w_state_chg;
  logic                w_inc_ok;
  logic [BLK_W-1:0]    w_next_blk;
  logic                w_next_phase;

  btn_repeat #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_inc_btn (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_inc),
    .clr   (w_state_chg),
    .pulse (w_inc_pulse)
  );

  assign w_rise_mode = btn_mode & ~r_mode_q;
  assign w_timeout   = (r_state != RUN) && (r_idle == IDLE_LAST);
  assign w_state_chg = (w_next_state != r_state);
  // A mode change in the same cycle swallows the increment.
  assign w_inc_ok    = w_inc_pulse & ~w_state_chg;
  assign set_mode    = r_state;

  always_ff @(posedge clk) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default first so no path through this block can infer a latch.
    w_next_state = r_state;
    if (w_timeout) begin
      w_next_state = RUN;
    end else if (w_rise_mode) begin
      case (r_state)
        RUN:      w_next_state = SET_HOUR;
        SET_HOUR: w_next_state = SET_MIN;
        SET_MIN:  w_next_state = SET_SEC;
        default:  w_next_state = RUN;
      endcase
    end
  end

  always_comb begin
    w_next_blk   = r_blk + 1'b1;
    w_next_phase = r_phase;
    if (w_state_chg || r_state == RUN) begin
      w_next_blk   = '0;
      w_next_phase = 1'b0;
    end else if (r_blk == BLK_LAST) begin
      w_next_blk   = '0;
      w_next_phase = ~r_phase;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode_q   <= 1'b0;
      r_pre      <= '0;
      r_idle     <= '0;
      r_blk      <= '0;
      r_phase    <= 1'b0;
      tick_en    <= 1'b0;
      inc_sec    <= 1'b0;
      inc_min    <= 1'b0;
      inc_hour   <= 1'b0;
      blink_mask <= '0;
    end else begin
      r_mode_q <= btn_mode;

      if (r_state != RUN || r_pre == PRE_LAST) r_pre <= '0;
      else                                     r_pre <= r_pre + 1'b1;

      // Any button activity restarts the idle window; saturate at the bound.
      if (r_state == RUN || w_state_chg || w_rise_mode || w_inc_pulse) r_idle <= '0;
      else if (r_idle != IDLE_LAST)                                       r_idle <= r_idle + 1'b1;

      r_blk   <= w_next_blk;
      r_phase <= w_next_phase;

      tick_en    <= (r_state == RUN) && (r_pre == PRE_LAST);
      inc_hour   <= w_inc_ok && (r_state == SET_HOUR);
      inc_min    <= w_inc_ok && (r_state == SET_MIN);
      inc_sec    <= w_inc_ok && (r_state == SET_SEC);
      blink_mask <= state_mask(w_next_state, w_next_phase);
    end
  end

endmodule
